// File: rtl/pwm_quad_gen.sv
// rtl/pwm_quad_gen.sv - 4-channel ESC PWM generator, duty applied at period wraps, clamp and watchdog
// Optional per-period duty slew limiting: define SLEW_LIMIT_EN.
module pwm_quad_gen #(
  parameter int CNT_WIDTH      = 18,
  parameter int PERIOD_DEFAULT = 250000,
  parameter int MIN_PULSE      = 100000,
  parameter int MAX_PULSE      = 200000,
  parameter int WDOG_PERIODS   = 8,
  parameter int SLEW_STEP      = 2000
) (
  input  logic                   s00_axi_aclk,
  input  logic                   s00_axi_areset,
  input  logic [4*CNT_WIDTH-1:0] duty_data,
  input  logic                   duty_valid,
  output logic                   duty_ready,
  input  logic [CNT_WIDTH-1:0]   period,
  input  logic                   arm,
  output logic [3:0]             pwm_out,
  output logic                   period_tick,
  output logic                   armed,
  output logic                   wdog_trip
);

  localparam int WW = $clog2(WDOG_PERIODS + 1);
  // Without slew limiting the step exceeds any possible duty change, so moves are immediate.
`ifdef SLEW_LIMIT_EN
  localparam int STEP_EFF = SLEW_STEP;
`else
  localparam int STEP_EFF = SLEW_STEP + MAX_PULSE;
`endif
  localparam logic [CNT_WIDTH-1:0] MIN_P   = CNT_WIDTH'(MIN_PULSE);
  localparam logic [CNT_WIDTH-1:0] MAX_P   = CNT_WIDTH'(MAX_PULSE);
  localparam logic [CNT_WIDTH-1:0] PER_DEF = CNT_WIDTH'(PERIOD_DEFAULT);
  localparam logic [CNT_WIDTH-1:0] PER_MIN = CNT_WIDTH'(MAX_PULSE + 2);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] STEP_N  = CNT_WIDTH'(STEP_EFF);
  localparam logic [CNT_WIDTH:0]   STEP_W  = (CNT_WIDTH+1)'(STEP_EFF);
  localparam logic [WW-1:0]        WDOG_N  = WW'(WDOG_PERIODS);

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] per_act;
  logic [CNT_WIDTH-1:0] duty_act     [4];
  logic [CNT_WIDTH-1:0] pending      [4];
  logic [CNT_WIDTH-1:0] duty_clamped [4];
  logic [CNT_WIDTH-1:0] duty_base    [4];
  logic [CNT_WIDTH-1:0] duty_goal    [4];
  logic [CNT_WIDTH-1:0] duty_next    [4];
  logic                 pending_full;
  logic [WW-1:0]        wdog_cnt;
  logic [WW-1:0]        wdog_inc;
  logic                 wrap;
  logic                 accept;
  logic                 wdog_trip_next;
  logic                 armed_next;

`ifdef SLEW_LIMIT_EN
  logic [CNT_WIDTH-1:0] target [4];
  always_comb begin
    for (int i = 0; i < 4; i++) duty_base[i] = target[i];
  end
`else
  always_comb begin
    for (int i = 0; i < 4; i++) duty_base[i] = duty_act[i];
  end
`endif

  assign wrap       = (cnt == per_act - ONE);
  assign duty_ready = !pending_full;
  assign accept     = duty_valid & !pending_full;

  always_comb begin
    wdog_inc = (wdog_cnt == WDOG_N) ? wdog_cnt : wdog_cnt + WW'(1);
    // Trip is sticky while arm is held; dropping arm is the only way to clear it.
    wdog_trip_next = arm & (wdog_trip | (!pending_full & (wdog_inc == WDOG_N)));
    armed_next     = arm & !wdog_trip_next;
    for (int i = 0; i < 4; i++) begin
      if (pending[i] < MIN_P)      duty_clamped[i] = MIN_P;
      else if (pending[i] > MAX_P) duty_clamped[i] = MAX_P;
      else                         duty_clamped[i] = pending[i];
      duty_goal[i] = pending_full ? duty_clamped[i] : duty_base[i];
      if ({1'b0, duty_goal[i]} > {1'b0, duty_act[i]} + STEP_W)
        duty_next[i] = duty_act[i] + STEP_N;
      else if ({1'b0, duty_act[i]} > {1'b0, duty_goal[i]} + STEP_W)
        duty_next[i] = duty_act[i] - STEP_N;
      else
        duty_next[i] = duty_goal[i];
`ifdef SLEW_LIMIT_EN
      if (!armed_next) duty_next[i] = MIN_P;
`endif
    end
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      cnt          <= '0;
      per_act      <= PER_DEF;
      pending_full <= 1'b0;
      wdog_cnt     <= '0;
      wdog_trip    <= 1'b0;
      armed        <= 1'b0;
      pwm_out      <= '0;
      period_tick  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        duty_act[i] <= MIN_P;
        pending[i]  <= '0;
`ifdef SLEW_LIMIT_EN
        target[i]   <= MIN_P;
`endif
      end
    end else begin
      period_tick <= wrap;
      for (int i = 0; i < 4; i++)
        pwm_out[i] <= (cnt < (armed ? duty_act[i] : MIN_P));
      if (wrap) begin
        cnt       <= '0;
        per_act   <= (period < PER_MIN) ? PER_MIN : period;
        wdog_cnt  <= pending_full ? '0 : wdog_inc;
        wdog_trip <= wdog_trip_next;
        armed     <= armed_next;
        for (int i = 0; i < 4; i++) begin
          duty_act[i] <= duty_next[i];
`ifdef SLEW_LIMIT_EN
          target[i]   <= duty_goal[i];
`endif
        end
      end else begin
        cnt <= cnt + ONE;
      end
      // A word accepted on the wrap cycle lands in pending and waits for the next wrap.
      if (wrap && pending_full) begin
        pending_full <= 1'b0;
      end else if (accept) begin
        pending_full <= 1'b1;
        for (int i = 0; i < 4; i++)
          pending[i] <= duty_data[i*CNT_WIDTH +: CNT_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_pwm_quad_gen.sv
// tb/tb_pwm_quad_gen.sv - self-checking bench for pwm_quad_gen against a period-level reference model
module tb_pwm_quad_gen;

  localparam int CW   = 8;
  localparam int PDEF = 40;
  localparam int MINP = 10;
  localparam int MAXP = 20;
  localparam int WD   = 3;
  localparam int SS   = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [4*CW-1:0] duty_data;
  logic            duty_valid;
  logic            duty_ready;
  logic [CW-1:0]   period;
  logic            arm;
  logic [3:0]      pwm_out;
  logic            period_tick;
  logic            armed;
  logic            wdog_trip;

  int vectors     = 0;
  int miscompares = 0;

  pwm_quad_gen #(
    .CNT_WIDTH(CW), .PERIOD_DEFAULT(PDEF), .MIN_PULSE(MINP),
    .MAX_PULSE(MAXP), .WDOG_PERIODS(WD), .SLEW_STEP(SS)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst), .duty_data(duty_data),
    .duty_valid(duty_valid), .duty_ready(duty_ready), .period(period),
    .arm(arm), .pwm_out(pwm_out), .period_tick(period_tick),
    .armed(armed), .wdog_trip(wdog_trip)
  );

  always #5 clk = ~clk;

  // Reference model: position inside the current period plus the values in force for it.
  int   m_pos, m_per, m_miss;
  int   m_duty[4], m_tgt[4], m_pend[4];
  bit   m_pfull, m_armed, m_trip;
  logic [3:0] e_pwm;
  logic e_tick, e_armed, e_trip, e_ready;
  int   width[4], last_width[4];
  int   ticks;

  function automatic int clampd(int v);
    return (v < MINP) ? MINP : ((v > MAXP) ? MAXP : v);
  endfunction

  function automatic int toward(int cur, int tgt);
    if (tgt > cur + SS) return cur + SS;
    if (tgt < cur - SS) return cur - SS;
    return tgt;
  endfunction

  function automatic logic [4*CW-1:0] pack(int a, int b, int c, int d);
    return {CW'(d), CW'(c), CW'(b), CW'(a)};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {pwm_out, period_tick, armed, wdog_trip, duty_ready};
  endfunction

  function automatic logic [7:0] exp_vec();
    return {e_pwm, e_tick, e_armed, e_trip, e_ready};
  endfunction

  task automatic model_reset();
    m_pos = 0; m_per = PDEF; m_miss = 0;
    m_pfull = 0; m_armed = 0; m_trip = 0;
    for (int i = 0; i < 4; i++) begin
      m_duty[i] = MINP; m_tgt[i] = MINP; m_pend[i] = 0;
      width[i] = 0; last_width[i] = 0;
    end
    ticks = 0;
  endtask

  task automatic step();
    bit acc, wr;
    logic [3:0] pw;
    acc = duty_valid && !m_pfull;
    wr  = (m_pos == m_per - 1);
    for (int i = 0; i < 4; i++) pw[i] = (m_pos < (m_armed ? m_duty[i] : MINP));
    if (wr) begin
      m_per = (int'(period) > MAXP + 2) ? int'(period) : MAXP + 2;
      if (m_pfull) begin
        m_miss = 0;
        for (int i = 0; i < 4; i++) begin
`ifdef SLEW_LIMIT_EN
          m_tgt[i] = clampd(m_pend[i]);
`else
          m_duty[i] = clampd(m_pend[i]);
`endif
        end
        m_pfull = 0;
      end else begin
        m_miss++;
      end
      m_trip  = arm && (m_trip || m_miss >= WD);
      m_armed = arm && !m_trip;
`ifdef SLEW_LIMIT_EN
      for (int i = 0; i < 4; i++) m_duty[i] = m_armed ? toward(m_duty[i], m_tgt[i]) : MINP;
`endif
      m_pos = 0;
    end else begin
      m_pos++;
    end
    if (acc) begin
      for (int i = 0; i < 4; i++) m_pend[i] = int'(duty_data[i*CW +: CW]);
      m_pfull = 1;
    end
    @(posedge clk); #1;
    e_pwm = pw; e_tick = wr; e_armed = m_armed; e_trip = m_trip; e_ready = !m_pfull;
    if (e_tick) begin
      last_width = width;
      for (int i = 0; i < 4; i++) width[i] = 0;
      ticks++;
    end
    for (int i = 0; i < 4; i++) if (pwm_out[i]) width[i]++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (dut_vec() !== 8'b0000_0001) begin
      miscompares++;
      $display("FAIL reset_state: got %b expected %b", dut_vec(), 8'b0000_0001);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_idle();
    for (int c = 0; c < 2 * PDEF; c++) begin
      step();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL idle_cycle %0d: got %b expected %b", c, dut_vec(), exp_vec());
      end
    end
    vectors++;
    if (ticks != 2) begin
      miscompares++;
      $display("FAIL idle_ticks: got %0d expected 2", ticks);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (last_width[i] != MINP) begin
        miscompares++;
        $display("FAIL idle_width ch%0d: got %0d expected %0d", i, last_width[i], MINP);
      end
    end
  endtask

  task automatic test_arm_clamp();
    int exp_w[4] = '{15, 10, 20, 20};
    arm = 1'b1;
    duty_data = pack(15, 5, 25, 20);
    duty_valid = 1'b1;
    ticks = 0;
    for (int c = 0; c < 400 && ticks < 8; c++) begin
      step();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL arm_cycle %0d: got %b expected %b", c, dut_vec(), exp_vec());
      end
      if (e_tick && ticks == 1) begin
        vectors++;
        if (armed !== 1'b1) begin
          miscompares++;
          $display("FAIL arm_first_wrap: got %b expected 1", armed);
        end
      end
    end
    vectors++;
    if (ticks < 8) begin
      miscompares++;
      $display("FAIL arm_timeout: got %0d ticks expected 8", ticks);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (last_width[i] != exp_w[i]) begin
        miscompares++;
        $display("FAIL clamp_width ch%0d: got %0d expected %0d", i, last_width[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit take;
    int held;
    duty_valid = 1'b0;
    ticks = 0;
    for (int c = 0; c < 100 && ticks < 1; c++) begin
      step();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL b2b_drain %0d: got %b expected %b", c, dut_vec(), exp_vec());
      end
    end
    duty_data = pack(12, 12, 12, 12);
    duty_valid = 1'b1;
    step();
    duty_data = pack(18, 18, 18, 18);
    held = 0;
    ticks = 0;
    for (int c = 0; c < 200 && ticks < 3; c++) begin
      take = duty_valid && duty_ready;
      step();
      if (take) duty_valid = 1'b0;
      if (ticks == 0 && duty_ready) held++;
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL b2b_cycle %0d: got %b expected %b", c, dut_vec(), exp_vec());
      end
`ifndef SLEW_LIMIT_EN
      if (e_tick && (ticks == 2 || ticks == 3)) begin
        vectors++;
        if (last_width[0] != ((ticks == 2) ? 12 : 18)) begin
          miscompares++;
          $display("FAIL b2b_width tick%0d: got %0d expected %0d", ticks, last_width[0], (ticks == 2) ? 12 : 18);
        end
      end
`endif
    end
    vectors++;
    if (held != 0 || ticks < 3) begin
      miscompares++;
      $display("FAIL b2b_hold: ready-before-wrap %0d ticks %0d expected 0 and 3", held, ticks);
    end
    duty_valid = 1'b0;
  endtask

  task automatic test_watchdog();
    bit take;
    int trip_at;
    duty_data = pack(16, 16, 16, 16);
    duty_valid = 1'b1;
    ticks = 0;
    trip_at = 0;
    for (int c = 0; c < 400 && ticks < 6; c++) begin
      take = duty_valid && duty_ready;
      step();
      if (take) duty_valid = 1'b0;
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL wdog_cycle %0d: got %b expected %b", c, dut_vec(), exp_vec());
      end
      if (e_tick && trip_at == 0 && wdog_trip) trip_at = ticks;
      if (e_tick && ticks == 5) begin
        vectors++;
        if (last_width[0] != MINP || armed !== 1'b0) begin
          miscompares++;
          $display("FAIL wdog_failsafe: width %0d armed %b expected %0d and 0", last_width[0], armed, MINP);
        end
        arm = 1'b0;
      end
    end
    vectors++;
    if (trip_at != 4) begin
      miscompares++;
      $display("FAIL wdog_trip_wrap: got %0d expected 4", trip_at);
    end
    vectors++;
    if (wdog_trip !== 1'b0 || ticks < 6) begin
      miscompares++;
      $display("FAIL wdog_clear: trip %b ticks %0d expected 0 and 6", wdog_trip, ticks);
    end
  endtask

  task automatic test_period_reset();
    int last_tick, gap;
    period = 8'd12;
    ticks = 0; last_tick = 0; gap = 0;
    for (int c = 1; c < 200 && ticks < 3; c++) begin
      step();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL short_cycle %0d: got %b expected %b", c, dut_vec(), exp_vec());
      end
      if (e_tick) begin gap = c - last_tick; last_tick = c; end
    end
    vectors++;
    if (gap != MAXP + 2) begin
      miscompares++;
      $display("FAIL short_period: got %0d expected %0d", gap, MAXP + 2);
    end
    repeat (3) step();
    vectors++;
    if (pwm_out !== 4'hf) begin
      miscompares++;
      $display("FAIL pre_reset_pulse: got %b expected 1111", pwm_out);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (dut_vec() !== 8'b0000_0001) begin
      miscompares++;
      $display("FAIL async_reset: got %b expected %b", dut_vec(), 8'b0000_0001);
    end
    #2 rst = 1'b0;
    model_reset();
    period = 8'(PDEF);
    last_tick = 0;
    for (int c = 1; c < 200 && ticks < 2; c++) begin
      step();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL post_reset %0d: got %b expected %b", c, dut_vec(), exp_vec());
      end
      if (e_tick) begin gap = c - last_tick; last_tick = c; end
    end
    vectors++;
    if (gap != PDEF || ticks != 2) begin
      miscompares++;
      $display("FAIL default_period: gap %0d ticks %0d expected %0d and 2", gap, ticks, PDEF);
    end
  endtask

  task automatic test_random();
    int pct;
    pct = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        arm    = ($urandom_range(0, 4) != 0);
        period = 8'($urandom_range(0, 50));
        case ($urandom_range(0, 2))
          0:       pct = 0;
          1:       pct = 5;
          default: pct = 50;
        endcase
      end
      duty_valid = ($urandom_range(0, 99) < pct);
      duty_data  = pack($urandom_range(0, 40), $urandom_range(0, 40),
                        $urandom_range(0, 255), $urandom_range(0, 40));
      step();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_cycle %0d: got %b expected %b", c, dut_vec(), exp_vec());
      end
    end
    duty_valid = 1'b0;
  endtask

`ifdef SLEW_LIMIT_EN
  task automatic test_slew();
    rst = 1'b1;
    arm = 1'b0;
    period = 8'(PDEF);
    duty_valid = 1'b0;
    #4 rst = 1'b0;
    model_reset();
    arm = 1'b1;
    duty_data = pack(10, 10, 10, 10);
    duty_valid = 1'b1;
    for (int c = 0; c < 500 && ticks < 9; c++) begin
      step();
      if (e_tick && ticks == 3) duty_data = pack(20, 20, 20, 20);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL slew_cycle %0d: got %b expected %b", c, dut_vec(), exp_vec());
      end
      if (e_tick && ticks >= 5) begin
        vectors++;
        if (last_width[0] != 12 + SS * (ticks - 5)) begin
          miscompares++;
          $display("FAIL slew_width tick%0d: got %0d expected %0d", ticks, last_width[0], 12 + SS * (ticks - 5));
        end
      end
    end
    duty_valid = 1'b0;
  endtask
`endif

  initial begin
    duty_data  = '0;
    duty_valid = 1'b0;
    period     = 8'(PDEF);
    arm        = 1'b0;
    test_reset();
    test_idle();
    test_arm_clamp();
    test_back_to_back();
    test_watchdog();
    test_period_reset();
    test_random();
`ifdef SLEW_LIMIT_EN
    test_slew();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
